// File: rtl/cevero_lockstep_checker_if.sv
// ============================================================================
// Module      : cevero_lockstep_checker_if
// Description : Carries the two packed core request buses into the lockstep
//               checker. The master drives them and the checker is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cevero_lockstep_checker_if;
    // {instr_req, instr_addr[31:0], data_req, data_we, data_be[3:0],
    //  data_addr[31:0], data_wdata[31:0]}
    logic [102:0] bus0_i;
    logic [102:0] bus1_i;

    modport master (output bus0_i, output bus1_i);
    modport slave  (input  bus0_i, input  bus1_i);
endinterface

`default_nettype wire

// File: rtl/cevero_lockstep_checker.sv
// ============================================================================
// Module      : cevero_lockstep_checker
// Description : Compares the instruction- and data-bus request streams of the
//               two CEVERO cores every cycle. On divergence it halts both
//               cores, then requests a rollback to the last agreed PC. After
//               MAX_ERR detections it stops the system until reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cevero_lockstep_checker #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
    parameter int unsigned RECOVERY_CYCLES = 4,
    parameter int unsigned MAX_ERR         = 10,
    parameter int unsigned CNT_W           = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    cevero_lockstep_checker_if.slave    bus_if,
    output logic                        error_o,
    output logic                        halt_o,
    output logic                        rollback_o,
    output logic [31:0]                 ckpt_pc_o,
    output logic [CNT_W-1:0]            err_count_o,
    output logic                        fatal_o,
    output logic [1:0]                  state_o
);

    localparam int unsigned RC_W = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;

    typedef struct packed {
        logic        instr_req;
        logic [31:0] instr_addr;
        logic        data_req;
        logic        data_we;
        logic [3:0]  data_be;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
    } bus_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALT     = 2'd1,
        ST_ROLLBACK = 2'd2,
        ST_FATAL    = 2'd3
    } state_t;

    bus_t             w_b0;
    bus_t             w_b1;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           state_q,    state_d;
    logic [RC_W-1:0]  rcnt_q,     rcnt_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic [31:0]      ckpt_q,     ckpt_d;
    logic             error_q,    error_d;
    logic             halt_q,     halt_d;
    logic             rollback_q, rollback_d;
    logic             fatal_q,    fatal_d;

    assign w_b0 = bus_if.bus0_i;
    assign w_b1 = bus_if.bus1_i;

    // Divergence detector: fields only matter when their req/we qualifiers are set on both cores.
    always_comb begin
        w_mismatch = 1'b0;
        if (w_b0.instr_req != w_b1.instr_req)
            w_mismatch = 1'b1;
        if (w_b0.instr_req && w_b1.instr_req && (w_b0.instr_addr != w_b1.instr_addr))
            w_mismatch = 1'b1;
        if (w_b0.data_req != w_b1.data_req)
            w_mismatch = 1'b1;
        if (w_b0.data_req && w_b1.data_req &&
            ({w_b0.data_we, w_b0.data_be, w_b0.data_addr} !=
             {w_b1.data_we, w_b1.data_be, w_b1.data_addr}))
            w_mismatch = 1'b1;
        if (w_b0.data_req && w_b1.data_req && w_b0.data_we && w_b1.data_we &&
            (w_b0.data_wdata != w_b1.data_wdata))
            w_mismatch = 1'b1;
    end

    assign w_cnt_inc = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + CNT_W'(1);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        err_cnt_d  = err_cnt_q;
        ckpt_d     = ckpt_q;
        error_d    = 1'b0;
        rollback_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_mismatch) begin
                    error_d   = 1'b1;
                    err_cnt_d = w_cnt_inc;
                    if ((MAX_ERR != 0) && (32'(w_cnt_inc) >= MAX_ERR)) begin
                        state_d = ST_FATAL;
                    end else begin
                        state_d = ST_HALT;
                        rcnt_d  = RC_W'(RECOVERY_CYCLES - 1);
                    end
                end else if (w_b0.instr_req && w_b1.instr_req) begin
                    ckpt_d = w_b0.instr_addr;
                end
            end
            ST_HALT: begin
                if (rcnt_q == '0) begin
                    state_d    = ST_ROLLBACK;
                    rollback_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - RC_W'(1);
                end
            end
            ST_ROLLBACK: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_FATAL;
            end
        endcase
        halt_d  = (state_d != ST_RUN);
        fatal_d = (state_d == ST_FATAL);
    end

    // State and output registers; reset wins in every state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            rcnt_q     <= '0;
            err_cnt_q  <= '0;
            ckpt_q     <= BOOT_ADDR;
            error_q    <= 1'b0;
            halt_q     <= 1'b0;
            rollback_q <= 1'b0;
            fatal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            err_cnt_q  <= err_cnt_d;
            ckpt_q     <= ckpt_d;
            error_q    <= error_d;
            halt_q     <= halt_d;
            rollback_q <= rollback_d;
            fatal_q    <= fatal_d;
        end
    end

    assign error_o     = error_q;
    assign halt_o      = halt_q;
    assign rollback_o  = rollback_q;
    assign ckpt_pc_o   = ckpt_q;
    assign err_count_o = err_cnt_q;
    assign fatal_o     = fatal_q;
    assign state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cevero_lockstep_checker.sv
// ============================================================================
// Module      : tb_cevero_lockstep_checker
// Description : Self-checking bench for cevero_lockstep_checker: a table of
//               single-cycle compare vectors plus hand-written recovery,
//               fatal and reset-during-recovery sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cevero_lockstep_checker;

    localparam int R = 4;

    logic        clk;
    logic        rst;
    logic        error_o, halt_o, rollback_o, fatal_o;
    logic [31:0] ckpt_pc_o;
    logic [7:0]  err_count_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    cevero_lockstep_checker_if ifc ();

    cevero_lockstep_checker #(
        .BOOT_ADDR       (32'h0000_0080),
        .RECOVERY_CYCLES (R),
        .MAX_ERR         (10),
        .CNT_W           (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_if      (ifc.slave),
        .error_o     (error_o),
        .halt_o      (halt_o),
        .rollback_o  (rollback_o),
        .ckpt_pc_o   (ckpt_pc_o),
        .err_count_o (err_count_o),
        .fatal_o     (fatal_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [102:0] b0;
        logic [102:0] b1;
        logic         exp_err;
        logic [31:0]  exp_ckpt;
        logic [7:0]   exp_cnt;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [102:0] mk(input logic ir, input logic [31:0] ia,
                                        input logic dr, input logic we, input logic [3:0] be,
                                        input logic [31:0] da, input logic [31:0] wd);
        return {ir, ia, dr, we, be, da, wd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [102:0] a, input logic [102:0] b);
        ifc.bus0_i = a;
        ifc.bus1_i = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Idle both cores for R+1 cycles so a recovery started at T completes (RUN at T+R+2).
    task automatic recover();
        drive('0, '0);
        for (int k = 0; k < R + 1; k++) tick();
    endtask

    initial begin
        logic [102:0] a, b;
        int           pulses;
        logic         seen;

        rst = 1'b0;
        drive('0, '0);

        // Vector table; counts and checkpoints accumulate from reset.
        vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0),                      mk(0, 0, 0, 0, 0, 0, 0),                      1'b0, 32'h80,  8'd0};
        vecs[1]  = '{mk(1, 32'h100, 0, 0, 0, 0, 0),                mk(1, 32'h100, 0, 0, 0, 0, 0),                1'b0, 32'h100, 8'd0};
        vecs[2]  = '{mk(1, 32'h104, 0, 0, 0, 0, 0),                mk(0, 32'h104, 0, 0, 0, 0, 0),                1'b1, 32'h100, 8'd1};
        vecs[3]  = '{mk(0, 32'h111, 0, 0, 0, 0, 0),                mk(0, 32'h222, 0, 0, 0, 0, 0),                1'b0, 32'h100, 8'd1};
        vecs[4]  = '{mk(1, 32'h104, 1, 0, 4'hF, 32'h1000, 32'hAAAA), mk(1, 32'h104, 1, 0, 4'hF, 32'h1000, 32'h5555), 1'b0, 32'h104, 8'd1};
        vecs[5]  = '{mk(1, 32'h108, 1, 1, 4'hF, 32'h1000, 32'hAAAA), mk(1, 32'h108, 1, 1, 4'hF, 32'h1000, 32'h5555), 1'b1, 32'h104, 8'd2};
        vecs[6]  = '{mk(0, 0, 1, 0, 4'h1, 32'h2000, 0),            mk(0, 0, 0, 0, 4'h1, 32'h2000, 0),            1'b1, 32'h104, 8'd3};
        vecs[7]  = '{mk(1, 32'h108, 0, 1, 4'h3, 32'h1234, 32'h1),  mk(1, 32'h108, 0, 0, 4'hC, 32'h4321, 32'h2),  1'b0, 32'h108, 8'd3};
        vecs[8]  = '{mk(0, 0, 1, 1, 4'h3, 32'h3000, 32'h7),        mk(0, 0, 1, 1, 4'h7, 32'h3000, 32'h7),        1'b1, 32'h108, 8'd4};
        vecs[9]  = '{mk(1, 32'h10C, 0, 0, 0, 0, 0),                mk(1, 32'h110, 0, 0, 0, 0, 0),                1'b1, 32'h108, 8'd5};
        vecs[10] = '{mk(0, 0, 1, 1, 4'hF, 32'h4000, 32'h9),        mk(0, 0, 1, 0, 4'hF, 32'h4000, 32'h9),        1'b1, 32'h108, 8'd6};
        vecs[11] = '{mk(1, 32'h200, 1, 1, 4'hF, 32'h5000, 32'hBEEF), mk(1, 32'h200, 1, 1, 4'hF, 32'h5000, 32'hBEEF), 1'b0, 32'h200, 8'd6};

        // Reset state
        do_reset();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_rollback", 32'(rollback_o), 32'd0);
        chk("rst_fatal", 32'(fatal_o), 32'd0);
        chk("rst_count", 32'(err_count_o), 32'd0);
        chk("rst_ckpt", ckpt_pc_o, 32'h80);

        // Table-driven single-cycle compare vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].b0, vecs[i].b1);
            tick();
            chk($sformatf("vec%0d_error", i), 32'(error_o), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_halt", i), 32'(halt_o), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_state", i), 32'(state_o), vecs[i].exp_err ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_ckpt", i), ckpt_pc_o, vecs[i].exp_ckpt);
            chk($sformatf("vec%0d_count", i), 32'(err_count_o), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_err) begin
                recover();
                chk($sformatf("vec%0d_back_to_run", i), 32'(state_o), 32'd0);
            end
        end

        // Identical streams, PC 0x80 .. 0x3FC
        do_reset();
        seen = 1'b0;
        for (int pc = 32'h80; pc <= 32'h3FC; pc += 4) begin
            a = mk(1, 32'(pc), 1, pc[2], 4'hF, 32'(pc) + 32'h1000, 32'(pc) ^ 32'hA5A5);
            drive(a, a);
            tick();
            if (error_o) seen = 1'b1;
        end
        chk("ident_no_error", 32'(seen), 32'd0);
        chk("ident_ckpt", ckpt_pc_o, 32'h3FC);
        chk("ident_state", 32'(state_o), 32'd0);

        // Instruction address divergence and full recovery timeline
        do_reset();
        a = mk(1, 32'h3C, 0, 0, 0, 0, 0);
        drive(a, a);
        tick();
        drive(mk(1, 32'h40, 0, 0, 0, 0, 0), mk(1, 32'h44, 0, 0, 0, 0, 0));
        tick();                                   // T+1
        chk("rec_t1_error", 32'(error_o), 32'd1);
        chk("rec_t1_halt", 32'(halt_o), 32'd1);
        chk("rec_t1_count", 32'(err_count_o), 32'd1);
        drive('0, '0);
        for (int t = 2; t <= R + 1; t++) begin
            tick();
            chk($sformatf("rec_t%0d_error", t), 32'(error_o), 32'd0);
            chk($sformatf("rec_t%0d_halt", t), 32'(halt_o), 32'd1);
            chk($sformatf("rec_t%0d_rollback", t), 32'(rollback_o), (t == R + 1) ? 32'd1 : 32'd0);
        end
        chk("rec_rollback_ckpt", ckpt_pc_o, 32'h3C);
        chk("rec_rollback_state", 32'(state_o), 32'd2);
        tick();                                   // T+R+2
        chk("rec_run_halt", 32'(halt_o), 32'd0);
        chk("rec_run_rollback", 32'(rollback_o), 32'd0);
        chk("rec_run_state", 32'(state_o), 32'd0);

        // Ten detections reach FATAL; further mismatches change nothing
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            drive(mk(1, 32'h40, 0, 0, 0, 0, 0), mk(1, 32'h44, 0, 0, 0, 0, 0));
            tick();
            if (n < 10) recover();
        end
        chk("fatal_error_pulse", 32'(error_o), 32'd1);
        chk("fatal_state", 32'(state_o), 32'd3);
        chk("fatal_flag", 32'(fatal_o), 32'd1);
        chk("fatal_count", 32'(err_count_o), 32'd10);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (error_o || !halt_o || !fatal_o || state_o != 2'd3 || rollback_o) seen = 1'b1;
        end
        chk("fatal_sticky", 32'(seen), 32'd0);
        chk("fatal_count_held", 32'(err_count_o), 32'd10);

        // Mismatch held through the whole recovery window
        do_reset();
        drive(mk(0, 0, 1, 1, 4'hF, 32'h10, 32'h1), mk(0, 0, 1, 1, 4'hF, 32'h10, 32'h2));
        pulses = 0;
        for (int t = 1; t <= R + 1; t++) begin
            tick();
            if (error_o) pulses++;
        end
        drive('0, '0);
        for (int t = 0; t < 3; t++) begin
            tick();
            if (error_o) pulses++;
        end
        chk("held_one_pulse", 32'(pulses), 32'd1);
        chk("held_count", 32'(err_count_o), 32'd1);
        chk("held_state", 32'(state_o), 32'd0);

        // Reset asserted at T+2 of a recovery
        do_reset();
        a = mk(1, 32'h500, 0, 0, 0, 0, 0);
        drive(a, a);
        tick();
        drive(mk(1, 32'h504, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
        tick();                                   // T+1
        drive('0, '0);
        tick();                                   // T+2
        rst = 1'b1;
        tick();                                   // T+3
        rst = 1'b0;
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_halt", 32'(halt_o), 32'd0);
        chk("midrst_count", 32'(err_count_o), 32'd0);
        chk("midrst_ckpt", ckpt_pc_o, 32'h80);
        seen = rollback_o;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rollback_o) seen = 1'b1;
        end
        chk("midrst_no_rollback", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
